// File: rtl/div_5x4_seq_ctrl.sv
// Sequential wrapper around the combinational 5-bit / 4-bit divider:
// operand handshake, settle timer, remainder and consistency check.
module div_5x4_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_a,
  input  logic [3:0] in_b,
  output logic [4:0] div_a,
  output logic [3:0] div_b,
  input  logic [4:0] div_q,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_q,
  output logic [3:0] out_r,
  output logic       out_dz,
  output logic       out_zero,
  output logic       out_chk_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [4:0] a_q;
  logic [3:0] b_q;
  logic [3:0] cnt_q;
  logic [4:0] q_q;
  logic [3:0] r_q;
  logic       dz_q;
  logic       zero_q;
  logic       chk_q;
  logic       valid_q;

  logic [8:0] prod;
  logic [8:0] a9;
  logic [8:0] diff;
  logic [3:0] r_d;
  logic       chk_d;

  // Product width covers 31*15, so the comparison against a never wraps.
  always_comb begin
    prod  = {4'b0, div_q} * {5'b0, b_q};
    a9    = {4'b0, a_q};
    diff  = a9 - prod;
    r_d   = 4'd0;
    chk_d = 1'b0;
    if (prod > a9) begin
      chk_d = 1'b1;
    end else begin
      r_d   = diff[3:0];
      chk_d = (diff >= {5'b0, b_q});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      zero_q  <= 1'b0;
      chk_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
            if (in_b == 4'd0) begin
              q_q     <= '0;
              r_q     <= '0;
              dz_q    <= 1'b1;
              zero_q  <= 1'b1;
              chk_q   <= 1'b0;
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q   <= CNT_INIT;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            q_q     <= div_q;
            r_q     <= r_d;
            dz_q    <= 1'b0;
            zero_q  <= (div_q == 5'd0);
            chk_q   <= chk_d;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE) && !rst;
  assign busy        = (state_q != IDLE);
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign out_valid   = valid_q;
  assign out_q       = q_q;
  assign out_r       = r_q;
  assign out_dz      = dz_q;
  assign out_zero    = zero_q;
  assign out_chk_err = chk_q;

endmodule

// File: tb/tb_div_5x4_seq_ctrl.sv
// Scoreboard bench for div_5x4_seq_ctrl: two instances
// (settle 1 and settle 3) driven by directed vectors.
module tb_div_5x4_seq_ctrl;

  typedef struct {
    int q;
    int r;
    int dz;
    int z;
    int c;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [1:0] iv, ir, ov, ordy, odz, oz, oce, bz, fen;
  logic [4:0] ia;
  logic [3:0] ib;
  logic [4:0] fv;
  logic [4:0] da[2];
  logic [3:0] db[2];
  logic [4:0] dq[2];
  logic [4:0] oq[2];
  logic [3:0] orr[2];

  exp_t sq0[$];
  exp_t sq1[$];

  // Reference divider; returns an obviously wrong value for b=0.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      if (fen[g]) dq[g] = fv;
      else if (db[g] == 4'd0) dq[g] = 5'h1F;
      else dq[g] = da[g] / {1'b0, db[g]};
    end
  end

  div_5x4_seq_ctrl #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(ia), .in_b(ib),
    .div_a(da[0]), .div_b(db[0]), .div_q(dq[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_q(oq[0]), .out_r(orr[0]),
    .out_dz(odz[0]), .out_zero(oz[0]),
    .out_chk_err(oce[0]), .busy(bz[0])
  );

  div_5x4_seq_ctrl #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia), .in_b(ib),
    .div_a(da[1]), .div_b(db[1]), .div_q(dq[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_q(oq[1]), .out_r(orr[1]),
    .out_dz(odz[1]), .out_zero(oz[1]),
    .out_chk_err(oce[1]), .busy(bz[1])
  );

  task automatic ck(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int qsize(int g);
    return (g == 0) ? sq0.size() : sq1.size();
  endfunction

  for (genvar g = 0; g < 2; g++) begin : mon
    int acc = 0;
    int lat = 0;
    logic ovp = 1'b0;
    logic [4:0] aa = '0;
    logic [3:0] bb = '0;
    always @(negedge clk) begin
      exp_t e;
      int n;
      if (rst) begin
        ovp = 1'b0;
      end else begin
        if (iv[g] && ir[g]) begin
          acc = cyc + 1;
          aa = ia;
          bb = ib;
        end
        if (bz[g]) begin
          ck($sformatf("u%0d.div_a", g), int'(da[g]), int'(aa));
          ck($sformatf("u%0d.div_b", g), int'(db[g]), int'(bb));
        end
        if (ov[g]) begin
          if (!ovp) lat = cyc - acc + 1;
          n = qsize(g);
          ck($sformatf("u%0d.expected_pending", g), (n > 0) ? 1 : 0, 1);
          ck($sformatf("u%0d.in_ready_low", g), int'(ir[g]), 0);
          if (n > 0) begin
            e = (g == 0) ? sq0[0] : sq1[0];
            ck($sformatf("u%0d.out_q", g), int'(oq[g]), e.q);
            ck($sformatf("u%0d.out_r", g), int'(orr[g]), e.r);
            ck($sformatf("u%0d.out_dz", g), int'(odz[g]), e.dz);
            ck($sformatf("u%0d.out_zero", g), int'(oz[g]), e.z);
            ck($sformatf("u%0d.out_chk_err", g), int'(oce[g]), e.c);
            ck($sformatf("u%0d.latency", g), lat, e.lat);
            if (ordy[g]) begin
              if (g == 0) void'(sq0.pop_front());
              else void'(sq1.pop_front());
            end
          end
        end
        ovp = ov[g];
      end
    end
  end

  task automatic issue(int g, logic [4:0] a, logic [3:0] b, exp_t e, bit push);
    int k;
    k = 0;
    @(posedge clk);
    #1;
    while (!ir[g] && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    ck($sformatf("u%0d.accept_ready", g), int'(ir[g]), 1);
    ia = a;
    ib = b;
    iv[g] = 1'b1;
    if (push) begin
      if (g == 0) sq0.push_back(e);
      else sq1.push_back(e);
    end
    @(posedge clk);
    #1;
    iv[g] = 1'b0;
  endtask

  task automatic drain(int g);
    int k;
    k = 0;
    while (qsize(g) > 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    ck($sformatf("u%0d.drain", g), qsize(g), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    iv = '0;
    ordy = 2'b11;
    fen = '0;
    fv = '0;
    ia = '0;
    ib = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      ck($sformatf("u%0d.rst_in_ready", g), int'(ir[g]), 0);
      ck($sformatf("u%0d.rst_out_valid", g), int'(ov[g]), 0);
      ck($sformatf("u%0d.rst_busy", g), int'(bz[g]), 0);
      ck($sformatf("u%0d.rst_flags", g), int'({odz[g], oz[g], oce[g]}), 0);
      ck($sformatf("u%0d.rst_out_q", g), int'(oq[g]), 0);
    end
    rst = 1'b0;

    issue(0, 5'd13, 4'd3, '{4, 1, 0, 0, 0, 2}, 1'b1);
    drain(0);
    issue(0, 5'd31, 4'd1, '{31, 0, 0, 0, 0, 2}, 1'b1);
    drain(0);
    issue(0, 5'd2, 4'd15, '{0, 2, 0, 1, 0, 2}, 1'b1);
    drain(0);

    fen[0] = 1'b1;
    fv = 5'h1F;
    issue(0, 5'd20, 4'd0, '{0, 0, 1, 1, 0, 1}, 1'b1);
    drain(0);
    fen[0] = 1'b0;

    ordy[0] = 1'b0;
    issue(0, 5'd25, 4'd4, '{6, 1, 0, 0, 0, 2}, 1'b1);
    k = 0;
    while (!ov[0] && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    ck("u0.bp_valid", int'(ov[0]), 1);
    for (int i = 0; i < 5; i++) begin
      ia = 5'd7;
      ib = 4'd2;
      iv[0] = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ck("u0.bp_in_ready_after", int'(ir[0]), 1);
    ck("u0.bp_valid_drop", int'(ov[0]), 0);
    issue(0, 5'd7, 4'd2, '{3, 1, 0, 0, 0, 2}, 1'b1);
    drain(0);

    fen[0] = 1'b1;
    fv = 5'd4;
    issue(0, 5'd10, 4'd3, '{4, 0, 0, 0, 1, 2}, 1'b1);
    drain(0);
    fv = 5'd2;
    issue(0, 5'd10, 4'd3, '{2, 4, 0, 0, 1, 2}, 1'b1);
    drain(0);
    fen[0] = 1'b0;

    issue(1, 5'd9, 4'd4, '{2, 1, 0, 0, 0, 4}, 1'b1);
    drain(1);
    issue(1, 5'd9, 4'd4, '{0, 0, 0, 0, 0, 0}, 1'b0);
    ck("u3.mid_busy", int'(bz[1]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    ck("u3.rst_busy", int'(bz[1]), 0);
    ck("u3.rst_valid", int'(ov[1]), 0);
    ck("u3.rst_flags", int'({odz[1], oz[1], oce[1]}), 0);
    ck("u3.rst_out_q", int'(oq[1]), 0);
    ck("u3.rst_in_ready", int'(ir[1]), 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    ck("u3.no_stale", int'(ov[1]), 0);
    ck("u3.idle_ready", int'(ir[1]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
